cpu_core: RTL and testbench

Single-clock 8-bit accumulator CPU core: A/B registers, instruction register, memory address register (MAR), program counter, 8-bit add/subtract ALU, and a step-counter sequencer that decodes opcode plus step into one active state per cycle. The core sits between an external asynchronous-read RAM and the top-level output and halt logic. Internal transfers use multiplexers; there are no tri-state buffers.

---
 rtl/cpu_core_pkg.sv | 43 ++++
 rtl/cpu_core_alu.sv | 29 ++
 rtl/cpu_core.sv | 151 +++++++++++++++
 tb/tb_cpu_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
//==============================================================================
// Module   : cpu_core_pkg
// Brief    : Opcode constants, sequencer state encoding and decode helper
//            for the 8-bit accumulator core.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_core_pkg;

  localparam logic [3:0] c_op_nop = 4'h0;
  localparam logic [3:0] c_op_lda = 4'h1;
  localparam logic [3:0] c_op_add = 4'h2;
  localparam logic [3:0] c_op_sub = 4'h3;
  localparam logic [3:0] c_op_sta = 4'h4;
  localparam logic [3:0] c_op_out = 4'h5;
  localparam logic [3:0] c_op_jmp = 4'h6;
  localparam logic [3:0] c_op_jez = 4'h7;
  localparam logic [3:0] c_op_hlt = 4'hF;

  typedef enum logic [3:0] {
    FETCH_PC   = 4'd0,
    FETCH_INST = 4'd1,
    LOAD_ADDR  = 4'd2,
    RAM_A      = 4'd3,
    RAM_B      = 4'd4,
    ADD        = 4'd5,
    SUB        = 4'd6,
    STORE_A    = 4'd7,
    OUT_A      = 4'd8,
    JUMP       = 4'd9,
    SKIP_JUMP  = 4'd10,
    HALT       = 4'd11
  } state_t;

  // Opcodes 8..E are unassigned and execute as NOP.
  function automatic logic is_nop(input logic [3:0] op);
    return (op == c_op_nop) || ((op >= 4'h8) && (op <= 4'hE));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_core_alu.sv
//==============================================================================
// Module   : cpu_core_alu
// Brief    : Combinational 8-bit add/subtract with carry out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] result,
  output logic       cout
);

  logic [7:0] w_b_sel;
  logic [8:0] w_sum;

  // Subtraction is two's complement: A + ~B + 1.
  assign w_b_sel = sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_sel} + {8'd0, sub};
  assign result  = w_sum[7:0];
  assign cout    = w_sum[8];

endmodule

`default_nettype wire

// File: rtl/cpu_core.sv
//==============================================================================
// Module   : cpu_core
// Brief    : 8-bit accumulator CPU core with step-counter sequencer.
//            Define CPU_CORE_TRACE_EN for simulation-only output/halt tracing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_core
  import cpu_core_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_re,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       halted,
  output logic       eq_zero,
  output logic       cout
);

  logic [7:0] r_a, r_b, r_ir, r_mar, r_pc;
  logic [3:0] r_step;
  logic [3:0] w_step_nxt;
  logic [3:0] w_op;
  logic [7:0] w_alu;
  logic       w_unused_ir_hi;
  state_t     w_state;

  assign w_op           = r_ir[3:0];
  assign w_unused_ir_hi = ^r_ir[7:4];

  cpu_core_alu u_alu (
    .a      (r_a),
    .b      (r_b),
    .sub    (w_state == SUB),
    .result (w_alu),
    .cout   (cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_step <= 4'd0;
    else       r_step <= w_step_nxt;
  end

  // During FETCH_INST the new opcode is still on mem_rdata, so NOP-class
  // instructions are recognised there to finish in two cycles.
  always_comb begin
    w_state    = FETCH_PC;
    w_step_nxt = r_step + 4'd1;
    case (r_step)
      4'd0: w_state = FETCH_PC;
      4'd1: begin
        w_state = FETCH_INST;
        if (is_nop(mem_rdata[3:0])) w_step_nxt = 4'd0;
      end
      4'd2: begin
        case (w_op)
          c_op_out: begin w_state = OUT_A; w_step_nxt = 4'd0; end
          c_op_hlt: begin w_state = HALT;  w_step_nxt = r_step; end
          c_op_lda, c_op_add, c_op_sub, c_op_sta, c_op_jmp, c_op_jez:
            w_state = FETCH_PC;
          default:  w_step_nxt = 4'd0;
        endcase
      end
      4'd3: begin
        case (w_op)
          c_op_lda, c_op_add, c_op_sub, c_op_sta: w_state = LOAD_ADDR;
          c_op_jmp: begin w_state = JUMP; w_step_nxt = 4'd0; end
          c_op_jez: begin
            w_state    = eq_zero ? JUMP : SKIP_JUMP;
            w_step_nxt = 4'd0;
          end
          default:  w_step_nxt = 4'd0;
        endcase
      end
      4'd4: begin
        case (w_op)
          c_op_lda: begin w_state = RAM_A;   w_step_nxt = 4'd0; end
          c_op_add, c_op_sub: w_state = RAM_B;
          c_op_sta: begin w_state = STORE_A; w_step_nxt = 4'd0; end
          default:  w_step_nxt = 4'd0;
        endcase
      end
      4'd5: begin
        w_step_nxt = 4'd0;
        if (w_op == c_op_add)      w_state = ADD;
        else if (w_op == c_op_sub) w_state = SUB;
      end
      default: w_step_nxt = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= 8'h00;
      r_b   <= 8'h00;
      r_ir  <= 8'h00;
      r_mar <= 8'h00;
      r_pc  <= RESET_PC;
    end else begin
      case (w_state)
        FETCH_PC:   r_mar <= r_pc;
        FETCH_INST: begin r_ir  <= mem_rdata; r_pc <= r_pc + 8'd1; end
        LOAD_ADDR:  begin r_mar <= mem_rdata; r_pc <= r_pc + 8'd1; end
        RAM_A:      r_a  <= mem_rdata;
        RAM_B:      r_b  <= mem_rdata;
        ADD, SUB:   r_a  <= w_alu;
        JUMP:       r_pc <= mem_rdata;
        SKIP_JUMP:  r_pc <= r_pc + 8'd1;
        default:    ;
      endcase
    end
  end

  assign mem_addr  = r_mar;
  assign mem_wdata = r_a;
  assign out_data  = r_a;
  assign eq_zero   = (r_a == 8'h00);
  assign mem_re    = (w_state == FETCH_INST) || (w_state == LOAD_ADDR) ||
                     (w_state == RAM_A) || (w_state == RAM_B) || (w_state == JUMP);
  assign mem_we    = (w_state == STORE_A);
  assign out_valid = (w_state == OUT_A);
  assign halted    = (w_state == HALT);

`ifdef CPU_CORE_TRACE_EN
  logic r_trace_halt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trace_halt <= 1'b0;
    end else begin
      if (out_valid) $display("Output: %d (%h)", r_a, r_a);
      if (halted && !r_trace_halt) begin
        $display("Halted.");
        $stop;
      end
      r_trace_halt <= halted;
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
//==============================================================================
// Module   : tb_cpu_core
// Brief    : Directed self-checking bench for cpu_core with a behavioural RAM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, out_data;
  logic       mem_re, mem_we, out_valid, halted, eq_zero, cout;

  logic [7:0] ram [256];
  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle history of the current run, index = cycle after reset release.
  logic [7:0]  h_addr [64];
  logic [7:0]  h_wdata[64];
  logic [7:0]  h_data [64];
  logic [63:0] h_re, h_we, h_ov, h_halt, h_ez, h_cout;

  cpu_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .halted    (halted),
    .eq_zero   (eq_zero),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_hi(input logic [63:0] v);
    for (int k = 0; k < 64; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic clear_ram();
    for (int k = 0; k < 256; k++) ram[k] = 8'h00;
  endtask

  task automatic load(input logic [7:0] base, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                      input logic [7:0] b5);
    ram[base]        = b0;
    ram[base + 8'd1] = b1;
    ram[base + 8'd2] = b2;
    ram[base + 8'd3] = b3;
    ram[base + 8'd4] = b4;
    ram[base + 8'd5] = b5;
  endtask

  task automatic sample(input int k);
    h_addr[k]  = mem_addr;
    h_wdata[k] = mem_wdata;
    h_data[k]  = out_data;
    h_re[k]    = mem_re;
    h_we[k]    = mem_we;
    h_ov[k]    = out_valid;
    h_halt[k]  = halted;
    h_ez[k]    = eq_zero;
    h_cout[k]  = cout;
  endtask

  task automatic run_cycles(input int first, input int ncyc);
    for (int k = first; k < first + ncyc; k++) begin
      #1;
      sample(k);
      @(negedge clk);
    end
  endtask

  task automatic start_run(input int ncyc);
    h_re = '0; h_we = '0; h_ov = '0; h_halt = '0; h_ez = '0; h_cout = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_cycles(0, ncyc);
  endtask

  initial begin
    // Reset state
    clear_ram();
    reset = 1'b1;
    #2;
    check("rst_mem_re",    mem_re,    1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_halted",    halted,    1'b0);
    check("rst_mem_addr",  mem_addr,  8'h00);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_eq_zero",   eq_zero,   1'b1);

    // LDA 10 / ADD 11 / OUT / HLT
    load(8'h00, 8'h01, 8'h10, 8'h02, 8'h11, 8'h05, 8'h0F);
    ram[8'h10] = 8'h05;
    ram[8'h11] = 8'h03;
    start_run(20);
    check("t1_re_cycle0",  h_re[0],   1'b0);
    check("t1_fetch_addr", h_addr[1], 8'h00);
    check("t1_fetch_re",   h_re[1],   1'b1);
    check("t1_ov_cycle",   first_hi(h_ov), 13);
    check("t1_ov_count",   $countones(h_ov), 1);
    check("t1_out_data",   h_data[13], 8'h08);
    check("t1_halt_cycle", first_hi(h_halt), 16);
    check("t1_halt_hold",  h_halt[19], 1'b1);
    check("t1_no_write",   $countones(h_we), 0);

    // SUB with borrow: 02 - 05
    clear_ram();
    load(8'h00, 8'h01, 8'h20, 8'h03, 8'h21, 8'h05, 8'h0F);
    ram[8'h20] = 8'h02;
    ram[8'h21] = 8'h05;
    start_run(16);
    check("t2a_cout",     h_cout[10], 1'b0);
    check("t2a_ov",       h_ov[13],   1'b1);
    check("t2a_out_data", h_data[13], 8'hFD);
    check("t2a_eq_zero",  h_ez[13],   1'b0);

    // SUB to zero: 05 - 05
    ram[8'h20] = 8'h05;
    start_run(16);
    check("t2b_cout",      h_cout[10], 1'b1);
    check("t2b_ez_before", h_ez[10],   1'b0);
    check("t2b_out_data",  h_data[13], 8'h00);
    check("t2b_eq_zero",   h_ez[13],   1'b1);

    // STA
    clear_ram();
    load(8'h00, 8'h01, 8'h20, 8'h04, 8'h30, 8'h0F, 8'h00);
    ram[8'h20] = 8'hAA;
    start_run(14);
    check("t3_we_count", $countones(h_we), 1);
    check("t3_we_cycle", first_hi(h_we), 9);
    check("t3_we_addr",  h_addr[9],  8'h30);
    check("t3_we_data",  h_wdata[9], 8'hAA);
    check("t3_ram",      ram[8'h30], 8'hAA);
    check("t3_halt",     first_hi(h_halt), 12);

    // JEZ taken
    clear_ram();
    load(8'h00, 8'h01, 8'h20, 8'h07, 8'h40, 8'h0F, 8'h00);
    ram[8'h20] = 8'h00;
    start_run(12);
    check("t4a_jez_taken", h_addr[10], 8'h40);

    // JEZ not taken
    ram[8'h20] = 8'h01;
    start_run(12);
    check("t4b_jez_skip", h_addr[10], 8'h04);

    // JMP FE with NOPs at FE/FF wrapping to 00
    clear_ram();
    load(8'h00, 8'h06, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00);
    start_run(12);
    check("t5_re_fp",   h_re[4],   1'b0);
    check("t5_addr_fe", h_addr[5], 8'hFE);
    check("t5_re_fe",   h_re[5],   1'b1);
    check("t5_addr_ff", h_addr[7], 8'hFF);
    check("t5_wrap",    h_addr[9], 8'h00);

    // Reset during RAM_B of ADD, then STA to 30
    clear_ram();
    load(8'h00, 8'h02, 8'h21, 8'h04, 8'h30, 8'h0F, 8'h00);
    ram[8'h21] = 8'h07;
    ram[8'h30] = 8'h55;
    h_re = '0; h_we = '0; h_ov = '0; h_halt = '0; h_ez = '0; h_cout = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_cycles(0, 4);
    #1;
    check("t6_in_ramb_addr", mem_addr, 8'h21);
    check("t6_in_ramb_re",   mem_re,   1'b1);
    reset = 1'b1;
    #1;
    check("t6_async_addr", mem_addr, 8'h00);
    check("t6_async_re",   mem_re,   1'b0);
    check("t6_async_a",    out_data, 8'h00);
    @(posedge clk);
    #1;
    check("t6_no_write", ram[8'h30], 8'h55);
    start_run(16);
    check("t6_restart_addr", h_addr[1], 8'h00);
    check("t6_we_cycle",     first_hi(h_we), 10);
    check("t6_we_data",      h_wdata[10], 8'h07);
    check("t6_ram",          ram[8'h30], 8'h07);
    check("t6_halt",         first_hi(h_halt), 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
